// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave word shifter with rx handshake and optional overrun flag
//
// Purpose: SPI slave (modes set by CPOL/CPHA). Receives MSB-first words on spi_mosi_i
// into rx_data_bo with a valid/ack handshake, and returns tx_data_bi words on spi_miso_o.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN (sticky overrun_o); undefined ties overrun_o to 0.
//
// Ports:
//   clk_i, rst_i         system clock, asynchronous active-high reset
//   tx_data_bi           next word returned to the master
//   tx_load_o            pulse: tx_data_bi was captured
//   rx_data_bo           last complete received word
//   rx_valid_o, rx_ack_i receive handshake
//   overrun_o            sticky lost-word flag
//   ready_o              block is idle
//   spi_*                SPI pins (spi_cs_i active-low)
module spi_slave_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] tx_data_bi,
  output logic                  tx_load_o,
  output logic [DATA_WIDTH-1:0] rx_data_bo,
  output logic                  rx_valid_o,
  input  logic                  rx_ack_i,
  output logic                  overrun_o,
  output logic                  ready_o,
  output logic                  spi_miso_o,
  input  logic                  spi_mosi_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_i
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic            L_POL    = (CPOL != 0);
  localparam logic            L_CPHA   = (CPHA != 0);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_sclk_q;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_sr;
  logic [DATA_WIDTH-1:0] r_rx_sr;
  logic                  r_miso_en;
  logic                  r_tx_load;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;

  logic                  w_lead;
  logic                  w_trail;
  logic                  w_active;
  logic                  w_sample;
  logic                  w_drive;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_word_done;
  logic [DATA_WIDTH-1:0] w_rx_next;

  // Edge detection compares the registered SCLK with the live pin, so an edge
  // is acted on at the first clk_i edge after the pin moves.
  assign w_lead      = (r_sclk_q == L_POL) && (spi_sclk_i != L_POL);
  assign w_trail     = (r_sclk_q != L_POL) && (spi_sclk_i == L_POL);
  assign w_active    = (r_state == S_SHIFT) && !spi_cs_i;
  assign w_sample    = w_active && (L_CPHA ? w_trail : w_lead);
  assign w_drive     = w_active && (L_CPHA ? w_lead : w_trail);
  assign w_word_done = w_sample && (r_bit_cnt == LAST_BIT);
  assign w_rx_next   = {r_rx_sr[DATA_WIDTH-2:0], spi_mosi_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus word-start load / shift decisions.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!spi_cs_i) begin
          w_next = S_SHIFT;
          // In CPHA=0 the first MSB must be on the line before the first edge.
          w_load = !L_CPHA;
        end
      end
      S_SHIFT: begin
        if (spi_cs_i) begin
          w_next = S_IDLE;
        end else if (w_drive) begin
          if (r_bit_cnt == '0) begin
            w_load = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclk_q   <= L_POL;
      r_bit_cnt  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_miso_en  <= 1'b0;
      r_tx_load  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_sclk_q  <= spi_sclk_i;
      r_tx_load <= w_load;

      if (w_load) begin
        r_tx_sr <= tx_data_bi;
      end else if (w_shift) begin
        r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
      end

      if (w_load) begin
        r_miso_en <= 1'b1;
      end else if (w_next == S_IDLE) begin
        r_miso_en <= 1'b0;
      end

      // CS high drops any partial word; the next assertion restarts at bit 0.
      if (spi_cs_i) begin
        r_bit_cnt <= '0;
        r_rx_sr   <= '0;
      end else if (w_sample) begin
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
        r_rx_sr   <= w_rx_next;
      end

      // A completing word takes priority over a simultaneous acknowledge.
      if (w_word_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
      end else if (rx_ack_i) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overrun <= 1'b0;
    end else if (w_word_done && r_rx_valid && !rx_ack_i) begin
      r_overrun <= 1'b1;
    end else if (rx_ack_i) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun_o = r_overrun;
`else
  assign overrun_o = 1'b0;
`endif

  assign tx_load_o  = r_tx_load;
  assign rx_data_bo = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign ready_o    = (r_state == S_IDLE);
  assign spi_miso_o = r_tx_sr[DATA_WIDTH-1] && r_miso_en && !spi_cs_i;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - randomized self-checking bench for spi_slave_ctrl (8/0/0 and 16/1/1)
module tb_spi_slave_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  sclk;
  logic [1:0]  cs_n;
  logic [1:0]  mosi;
  logic [1:0]  ack;
  wire  [1:0]  miso;
  wire  [1:0]  load;
  wire  [1:0]  valid;
  wire  [1:0]  ovr;
  wire  [1:0]  ready;
  wire  [7:0]  rx0;
  wire  [15:0] rx1;
  wire  [7:0]  tx0;
  wire  [15:0] tx1;

  logic [31:0] tx_tab [2][16];
  int          load_cnt [2];
  logic [31:0] m_words [4];

  logic [31:0] m_data [2];
  bit          m_valid [2];
  bit          m_ovr [2];

  int n_checks = 0;
  int n_errs   = 0;

  assign tx0 = tx_tab[0][load_cnt[0] % 16][7:0];
  assign tx1 = tx_tab[1][load_cnt[1] % 16][15:0];

  spi_slave_ctrl #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .tx_data_bi(tx0), .tx_load_o(load[0]),
    .rx_data_bo(rx0), .rx_valid_o(valid[0]), .rx_ack_i(ack[0]), .overrun_o(ovr[0]),
    .ready_o(ready[0]), .spi_miso_o(miso[0]), .spi_mosi_i(mosi[0]),
    .spi_sclk_i(sclk[0]), .spi_cs_i(cs_n[0])
  );

  spi_slave_ctrl #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .tx_data_bi(tx1), .tx_load_o(load[1]),
    .rx_data_bo(rx1), .rx_valid_o(valid[1]), .rx_ack_i(ack[1]), .overrun_o(ovr[1]),
    .ready_o(ready[1]), .spi_miso_o(miso[1]), .spi_mosi_i(mosi[1]),
    .spi_sclk_i(sclk[1]), .spi_cs_i(cs_n[1])
  );

  // Each tx_load_o pulse advances the word presented on tx_data_bi.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (load[s]) load_cnt[s] = load_cnt[s] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int wd(input int s);
    return (s == 1) ? 16 : 8;
  endfunction

  function automatic logic [31:0] msk(input int s);
    return (s == 1) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] rxd(input int s);
    return (s == 1) ? {16'h0, rx1} : {24'h0, rx0};
  endfunction

  // Reference behaviour of the receive handshake, expressed as event rules.
  task automatic model_complete(input int s, input bit acked, input logic [31:0] d);
`ifdef SPI_SLAVE_OVERRUN_EN
    if (m_valid[s] && !acked) m_ovr[s] = 1'b1;
    else if (acked) m_ovr[s] = 1'b0;
`endif
    m_data[s]  = d;
    m_valid[s] = 1'b1;
  endtask

  task automatic model_ack(input int s);
    m_valid[s] = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    m_ovr[s] = 1'b0;
`endif
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_data[s] = '0; m_valid[s] = 1'b0; m_ovr[s] = 1'b0;
    end
  endtask

  task automatic check_status(input int s);
    chk("rx_valid_state", 32'(valid[s]), 32'(m_valid[s]));
    chk("overrun_state", 32'(ovr[s]), 32'(m_ovr[s]));
    chk("rx_data_state", rxd(s), m_data[s]);
  endtask

  task automatic do_ack(input int s);
    ack[s] = 1'b1;
    cyc(1);
    ack[s] = 1'b0;
    cyc(1);
    model_ack(s);
    check_status(s);
  endtask

  task automatic set_tx(input int s, input int k, input logic [31:0] d);
    tx_tab[s][(load_cnt[s] + k) % 16] = d & msk(s);
  endtask

  // Master: nw full words from m_words, or (nw==0) pbits bits of m_words[0].
  // The transaction ends right after its last sample edge; SCLK returns to idle with CS high.
  task automatic xfer(input int s, input int nw, input int pbits, input bit ack_last);
    int w;
    int nbits;
    int base;
    int wi;
    int bi;
    bit last;
    logic pol;
    logic [31:0] got [4];
    w     = wd(s);
    pol   = (s == 1);
    nbits = (nw == 0) ? pbits : nw * w;
    base  = load_cnt[s];
    for (int k = 0; k < 4; k++) got[k] = '0;
    cs_n[s] = 1'b0;
    cyc(3);
    chk("ready_busy", 32'(ready[s]), 32'd0);
    for (int b = 0; b < nbits; b++) begin
      wi   = b / w;
      bi   = w - 1 - (b % w);
      last = (b == nbits - 1);
      mosi[s] = m_words[wi][bi];
      cyc(2);
      if (s == 0) begin
        got[wi][bi] = miso[s];
        sclk[s] = ~pol;
        ack[s]  = last && ack_last;
        cyc(1);
        ack[s] = 1'b0;
        cyc(2);
        if (!last) begin
          sclk[s] = pol;
          cyc(3);
        end
      end else begin
        sclk[s] = ~pol;
        cyc(3);
        got[wi][bi] = miso[s];
        sclk[s] = pol;
        ack[s]  = last && ack_last;
        cyc(1);
        ack[s] = 1'b0;
        cyc(2);
      end
      if (nw > 0 && (b % w) == w - 1) begin
        model_complete(s, last && ack_last, m_words[wi]);
        chk("rx_word", rxd(s), m_words[wi]);
        chk("rx_valid_word", 32'(valid[s]), 32'd1);
      end
    end
    cs_n[s] = 1'b1;
    #1;
    chk("miso_cs_high", 32'(miso[s]), 32'd0);
    cyc(1);
    sclk[s] = pol;
    cyc(3);
    chk("ready_idle", 32'(ready[s]), 32'd1);
    for (int k = 0; k < nw; k++) begin
      chk("miso_word", got[k], tx_tab[s][(base + k) % 16] & msk(s));
    end
    chk("load_pulses", 32'(load_cnt[s] - base), (nw == 0) ? 32'd1 : 32'(nw));
    check_status(s);
  endtask

  initial begin
    int s;
    int nw;
    sclk = 2'b10;
    cs_n = 2'b11;
    mosi = 2'b00;
    ack  = 2'b00;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 16; j++) tx_tab[i][j] = '0;
    model_reset();

    cyc(2);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(ready[i]), 32'd1);
      chk("rst_valid", 32'(valid[i]), 32'd0);
      chk("rst_overrun", 32'(ovr[i]), 32'd0);
      chk("rst_rx_data", rxd(i), 32'd0);
      chk("rst_miso", 32'(miso[i]), 32'd0);
      chk("rst_tx_load", 32'(load[i]), 32'd0);
    end
    #2 rst = 1'b0;
    cyc(2);

    // Mode 0, single byte.
    set_tx(0, 0, 32'h3C);
    m_words[0] = 32'hA5;
    xfer(0, 1, 0, 1'b0);

    // Partial word aborted by CS, then a full word.
    m_words[0] = 32'h000000FF;
    set_tx(0, 0, 32'h81);
    xfer(0, 0, 3, 1'b0);
    m_words[0] = 32'h5A;
    set_tx(0, 0, 32'hC3);
    xfer(0, 1, 0, 1'b0);
    do_ack(0);

    // Mode 3, 16-bit, two back-to-back words.
    set_tx(1, 0, 32'hCAFE);
    set_tx(1, 1, 32'h5A5A);
    m_words[0] = 32'h1234;
    m_words[1] = 32'hBEEF;
    xfer(1, 2, 0, 1'b0);
    do_ack(1);

    // Ack coincident with completion of the next word.
    set_tx(0, 0, 32'h11);
    m_words[0] = 32'h69;
    xfer(0, 1, 0, 1'b0);
    set_tx(0, 0, 32'h22);
    m_words[0] = 32'h96;
    xfer(0, 1, 0, 1'b1);
    do_ack(0);

    // Two words with no ack, then ack clears the flags.
    set_tx(0, 0, 32'h0F);
    set_tx(0, 1, 32'hF0);
    m_words[0] = 32'h12;
    m_words[1] = 32'hED;
    xfer(0, 2, 0, 1'b0);
    do_ack(0);

    // Asynchronous reset in the middle of a word.
    set_tx(0, 0, 32'hFF);
    cs_n[0] = 1'b0;
    mosi[0] = 1'b1;
    cyc(3);
    sclk[0] = 1'b1; cyc(3);
    sclk[0] = 1'b0; cyc(3);
    sclk[0] = 1'b1; cyc(3);
    #3 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk("arst_ready", 32'(ready[i]), 32'd1);
      chk("arst_miso", 32'(miso[i]), 32'd0);
      chk("arst_tx_load", 32'(load[i]), 32'd0);
      check_status(i);
    end
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    cyc(1);
    #2 rst = 1'b0;
    cyc(2);
    set_tx(0, 0, 32'hB4);
    m_words[0] = 32'h3E;
    xfer(0, 1, 0, 1'b0);
    set_tx(1, 0, 32'h8001);
    m_words[0] = 32'h7FFE;
    xfer(1, 1, 0, 1'b0);

    // Randomized transactions on both modes.
    for (int it = 0; it < 12; it++) begin
      s  = int'($urandom_range(0, 1));
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) begin
        m_words[k] = $urandom() & msk(s);
        set_tx(s, k, $urandom());
      end
      xfer(s, nw, 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) do_ack(s);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
